// File: rtl/inv_key_sched_pkg.sv
// inv_key_sched_pkg: FSM state, key width and legal AES round-key counts shared by inv_key_sched.
package inv_key_sched_pkg;
   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DONE} state_t;
   localparam int KEY_W = 128;
   localparam logic [4:0] NR_128 = 5'd11;
   localparam logic [4:0] NR_192 = 5'd13;
   localparam logic [4:0] NR_256 = 5'd15;
   function automatic logic nr_legal(input logic [4:0] n, input int max_keys);
      return (n == NR_128 || n == NR_192 || n == NR_256) && int'(n) <= max_keys;
   endfunction
endpackage

// File: rtl/inv_key_sched_key_slice_sel.sv
// key_slice_sel: picks round key i_idx out of the flat expanded key (key 0 in the most significant slice).
module key_slice_sel
   import inv_key_sched_pkg::*;
#(
   parameter int NUM_KEYS = 15
) (
   input  logic [KEY_W*NUM_KEYS-1:0] i_key_exp,
   input  logic [3:0]                i_idx,
   output logic [KEY_W-1:0]          o_key
);
   logic [KEY_W-1:0] w_keys [NUM_KEYS];
   for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
      assign w_keys[k] = i_key_exp[KEY_W*(NUM_KEYS-k)-1 -: KEY_W];
   end
   assign o_key = (int'(i_idx) < NUM_KEYS) ? w_keys[i_idx] : '0;
endmodule

// File: rtl/inv_key_sched.sv
// inv_key_sched: issues AES round keys last-first over a valid/ready handshake for the inverse cipher.
// Define INV_KEY_SCHED_FWD_EN to add i_encrypt, which selects ascending (forward cipher) order.
module inv_key_sched
   import inv_key_sched_pkg::*;
#(
   parameter int NUM_KEYS_MAX = 15
) (
   input  logic                          i_clk,
   input  logic                          i_rst_n,
   input  logic                          i_start,
`ifdef INV_KEY_SCHED_FWD_EN
   input  logic                          i_encrypt,
`endif
   input  logic [4:0]                    i_num_rounds,
   input  logic [KEY_W*NUM_KEYS_MAX-1:0] i_key_exp,
   output logic [KEY_W-1:0]              o_round_key,
   output logic                          o_key_valid,
   input  logic                          i_key_ready,
   output logic [3:0]                    o_round_idx,
   output logic                          o_first_key,
   output logic                          o_last_key,
   output logic                          o_busy,
   output logic                          o_done,
   output logic                          o_err
);
   state_t           r_state;
   logic [4:0]       r_n;
   logic [3:0]       r_idx;
   logic [KEY_W-1:0] r_round_key;
   logic             r_valid, r_busy, r_done, r_err;
   logic             w_enc_req, w_fwd, w_hs;
   logic [3:0]       w_nm1, w_rnm1, w_start_idx, w_first_idx, w_end_idx, w_step_idx, w_sel_idx;
   logic [KEY_W-1:0] w_key;
`ifdef INV_KEY_SCHED_FWD_EN
   logic             r_fwd;
   assign w_enc_req = i_encrypt;
   assign w_fwd     = r_fwd;
`else
   assign w_enc_req = 1'b0;
   assign w_fwd     = 1'b0;
`endif
   assign w_nm1       = 4'(i_num_rounds - 5'd1);
   assign w_rnm1      = 4'(r_n - 5'd1);
   assign w_start_idx = w_enc_req ? 4'd0 : w_nm1;
   assign w_first_idx = w_fwd ? 4'd0 : w_rnm1;
   assign w_end_idx   = w_fwd ? w_rnm1 : 4'd0;
   assign w_step_idx  = w_fwd ? r_idx + 4'd1 : r_idx - 4'd1;
   // the mux looks one key ahead so the register loads the next key on the accepting edge
   assign w_sel_idx   = (r_state == S_ISSUE) ? w_step_idx : w_start_idx;
   assign w_hs        = r_valid && i_key_ready;
   key_slice_sel #(.NUM_KEYS(NUM_KEYS_MAX)) u_key_slice_sel (
      .i_key_exp (i_key_exp),
      .i_idx     (w_sel_idx),
      .o_key     (w_key)
   );
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= S_IDLE;
         r_n         <= '0;
         r_idx       <= '0;
         r_round_key <= '0;
         r_valid     <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
`ifdef INV_KEY_SCHED_FWD_EN
         r_fwd       <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         case (r_state)
            S_IDLE: if (i_start) begin
               if (nr_legal(i_num_rounds, NUM_KEYS_MAX)) begin
                  r_n         <= i_num_rounds;
                  r_idx       <= w_start_idx;
                  r_round_key <= w_key;
                  r_valid     <= 1'b1;
                  r_busy      <= 1'b1;
                  r_state     <= S_ISSUE;
`ifdef INV_KEY_SCHED_FWD_EN
                  r_fwd       <= w_enc_req;
`endif
               end else begin
                  r_err <= 1'b1;
               end
            end
            S_ISSUE: if (w_hs) begin
               if (r_idx == w_end_idx) begin
                  r_valid <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  r_idx       <= w_step_idx;
                  r_round_key <= w_key;
               end
            end
            S_DONE: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
   assign o_round_key = r_round_key;
   assign o_key_valid = r_valid;
   assign o_round_idx = r_idx;
   assign o_first_key = r_valid && (r_idx == w_first_idx);
   assign o_last_key  = r_valid && (r_idx == w_end_idx);
   assign o_busy      = r_busy;
   assign o_done      = r_done;
   assign o_err       = r_err;
endmodule

// File: doc/inv_key_sched.md
INV_KEY_SCHED -- requirements
Module: inv_key_sched

Interface
REQ-001 Parameter: NUM_KEYS_MAX, default 15, meaning maximum number of 128-bit round keys held in key_exp.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request to begin a key sequence; sampled only in IDLE.
REQ-005 num_rounds  input  5  round-key count; legal values 11, 13 and 15.
REQ-006 key_exp  input  1920  expanded key, bit 0 MSB, key k occupies bits [128k : 128k+127]; held stable by the source while busy=1.
REQ-007 round_key  output  128  current round key to the inverse-round datapath.
REQ-008 key_valid  output  1  round_key is valid.
REQ-009 key_ready  input  1  datapath accepts round_key this cycle.
REQ-010 round_idx  output  4  index of the key currently presented.
REQ-011 first_key, last_key  output  1 each  presented key is the first (initial AddRoundKey) or the last (no InvMixColumns) of the sequence.
REQ-012 busy  output  1  high in ISSUE and DONE.
REQ-013 done  output  1  one-cycle pulse when the sequence completes.
REQ-014 err  output  1  one-cycle pulse on a start with illegal num_rounds.

Function
REQ-015 The FSM SHALL have the states IDLE, ISSUE and DONE.
REQ-016 In IDLE, start=1 with legal num_rounds SHALL latch n=num_rounds, set idx=n-1 and round_key=key k=n-1, then move to ISSUE; key_valid rises one cycle after start.
REQ-017 In IDLE, start=1 with illegal num_rounds SHALL pulse err for one cycle and remain in IDLE.
REQ-018 In ISSUE, key_valid SHALL be 1; round_key, round_idx, first_key and last_key SHALL hold stable until a handshake (key_valid&&key_ready).
REQ-019 On a handshake with idx>0, idx SHALL decrement and round_key SHALL load key idx-1 in the same edge, so back-to-back keys can be accepted every cycle.
REQ-020 On a handshake with idx==0, the FSM SHALL move to DONE and drop key_valid.
REQ-021 DONE SHALL assert done for exactly one cycle and then return to IDLE.
REQ-022 first_key SHALL be (idx==n-1) and last_key SHALL be (idx==0), both gated by key_valid.
REQ-023 start SHALL be ignored outside IDLE; changes to num_rounds after latching SHALL be ignored.
REQ-024 Total latency SHALL be 1 + n cycles from start to done when key_ready is held at 1.

Reset
REQ-025 rst=0 SHALL force IDLE, idx=0, round_key=0, and key_valid, first_key, last_key, busy, done and err to 0, including during the middle of a sequence; no done pulse SHALL follow the abort.

Configuration
REQ-026 With INV_KEY_SCHED_FWD_EN defined, an input port encrypt (1 bit, sampled with start) SHALL be present; encrypt=1 SHALL issue keys in ascending order 0..n-1, with first_key at idx==0 and last_key at idx==n-1.
REQ-027 Without INV_KEY_SCHED_FWD_EN, the encrypt port SHALL be absent and only the descending order SHALL be supported.

Structure
REQ-028 A shared package SHALL hold the FSM state enum, the key width (128) and the legal round-count constants 11, 13 and 15.
REQ-029 The key-slice multiplexer SHALL be a sub-module, key_slice_sel (index in, 128-bit key out).

Verification
REQ-030 num_rounds=11, key_ready=1, start pulse: the bench SHALL check keys 10..0 on consecutive cycles, first_key with key 10, last_key with key 0, and done 12 cycles after start.
REQ-031 num_rounds=15, key_ready toggling 1/0: the bench SHALL check that every key is held until accepted, 15 keys in total, and that round_key matches key_exp[1792:1919] first.
REQ-032 num_rounds=12, start: the bench SHALL check a single err pulse, busy=0 and key_valid=0.
REQ-033 start re-asserted during ISSUE with num_rounds=13: the bench SHALL check that the sequence is unaffected and that exactly one done pulse occurs.
REQ-034 rst=0 after the 5th key of a num_rounds=13 sequence: the bench SHALL check that all outputs are 0 at once, that no done pulse occurs, and that a fresh start works.
REQ-035 With INV_KEY_SCHED_FWD_EN defined, encrypt=1 and num_rounds=11: the bench SHALL check keys 0..10 in ascending order, first_key with key 0 and last_key with key 10.
